// File: rtl/joy_dir_resolver.sv
// Multi-player joystick conditioner: synchronise, debounce, resolve opposing/diagonal
// presses (last pressed wins) and restrict to 8/4/2-way per the runtime mode.
module joy_dir_resolver #(
  parameter int NPLAYERS    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 0
) (
  input  logic                  I_CLK,
  input  logic                  I_RESETn,
  input  logic [1:0]            I_MODE,
  input  logic [4*NPLAYERS-1:0] I_JOY,
  output logic [4*NPLAYERS-1:0] O_JOY,
  output logic [NPLAYERS-1:0]   O_CHANGED
);

  localparam int NB = 4 * NPLAYERS;

  logic [NB-1:0] sync_q [SYNC_STAGES];
  logic [NB-1:0] s;
  logic [NB-1:0] stable;
  logic [NB-1:0] stable_q;

  always_ff @(posedge I_CLK or negedge I_RESETn) begin
    if (!I_RESETn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= I_JOY;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE == 0) begin : g_no_deb
      assign stable = s;
    end else begin : g_deb
      localparam int CW = $clog2(DEBOUNCE + 1);
      // Accept on the DEBOUNCE-th consecutive differing sample.
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

      logic [NB-1:0][CW-1:0] cnt_q;
      logic [NB-1:0]         deb_q;

      always_ff @(posedge I_CLK or negedge I_RESETn) begin
        if (!I_RESETn) begin
          cnt_q <= '0;
          deb_q <= '0;
        end else begin
          for (int b = 0; b < NB; b++) begin
            if (s[b] == deb_q[b]) begin
              cnt_q[b] <= '0;
            end else if (cnt_q[b] == CNT_LAST) begin
              deb_q[b] <= s[b];
              cnt_q[b] <= '0;
            end else begin
              cnt_q[b] <= cnt_q[b] + CW'(1);
            end
          end
        end
      end

      assign stable = deb_q;
    end
  endgenerate

  always_ff @(posedge I_CLK or negedge I_RESETn) begin
    if (!I_RESETn) stable_q <= '0;
    else           stable_q <= stable;
  end

  for (genvar p = 0; p < NPLAYERS; p++) begin : g_player
    logic [3:0] st;
    logic [3:0] rise;
    logic [1:0] last_h_q, last_h_d;
    logic [1:0] last_v_q, last_v_d;
    logic       axis_v_q, axis_v_d;
    logic [1:0] h, v;
    logic [3:0] out_d;
    logic [3:0] joy_q;
    logic       chg_q;

    assign st   = stable[4*p +: 4];
    assign rise = st & ~stable_q[4*p +: 4];

    // Bit order inside a player nibble: {U,D,L,R}.
    always_comb begin
      last_h_d = last_h_q;
      if (rise[1])      last_h_d = 2'b10;
      else if (rise[0]) last_h_d = 2'b01;

      last_v_d = last_v_q;
      if (rise[3])      last_v_d = 2'b10;
      else if (rise[2]) last_v_d = 2'b01;

      axis_v_d = axis_v_q;
      if (|rise[3:2])      axis_v_d = 1'b1;
      else if (|rise[1:0]) axis_v_d = 1'b0;

      h = (&st[1:0]) ? last_h_d : st[1:0];
      v = (&st[3:2]) ? last_v_d : st[3:2];

      case (I_MODE)
        2'd1: begin
          if (h != 2'b00 && v != 2'b00) out_d = axis_v_d ? {v, 2'b00} : {2'b00, h};
          else                          out_d = {v, h};
        end
        2'd2:    out_d = {2'b00, h};
        default: out_d = {v, h};
      endcase
    end

    always_ff @(posedge I_CLK or negedge I_RESETn) begin
      if (!I_RESETn) begin
        last_h_q <= 2'b00;
        last_v_q <= 2'b00;
        axis_v_q <= 1'b0;
        joy_q    <= 4'b0000;
        chg_q    <= 1'b0;
      end else begin
        last_h_q <= last_h_d;
        last_v_q <= last_v_d;
        axis_v_q <= axis_v_d;
        joy_q    <= out_d;
        chg_q    <= (out_d != joy_q);
      end
    end

    assign O_JOY[4*p +: 4] = joy_q;
    assign O_CHANGED[p]    = chg_q;
  end

endmodule

// File: tb/tb_joy_dir_resolver.sv
// Bench for joy_dir_resolver: two instances (no debounce / debounce 4) against a
// cycle reference model, plus directed scenarios with fixed expectations.
module tb_joy_dir_resolver;

  localparam int NP   = 2;
  localparam int SYNC = 2;

  logic         clk;
  logic         rst_n;
  logic [1:0]   mode;
  logic [7:0]   joy_in;
  logic [7:0]   joy0, joy4;
  logic [1:0]   chg0, chg4;

  int n_vec = 0;
  int n_err = 0;

  joy_dir_resolver #(.NPLAYERS(NP), .SYNC_STAGES(SYNC), .DEBOUNCE(0)) u_d0 (
    .I_CLK(clk), .I_RESETn(rst_n), .I_MODE(mode), .I_JOY(joy_in),
    .O_JOY(joy0), .O_CHANGED(chg0)
  );

  joy_dir_resolver #(.NPLAYERS(NP), .SYNC_STAGES(SYNC), .DEBOUNCE(4)) u_d4 (
    .I_CLK(clk), .I_RESETn(rst_n), .I_MODE(mode), .I_JOY(joy_in),
    .O_JOY(joy4), .O_CHANGED(chg4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state, index 0 = no debounce, 1 = debounce 4.
  int         deb [2] = '{0, 4};
  logic [7:0] pipe [2][SYNC];
  logic [7:0] stab [2];
  logic [7:0] stabq [2];
  int         run [2][8];
  int         last_h [2][NP];   // 0 none, 1 right, 2 left
  int         last_v [2][NP];   // 0 none, 1 down, 2 up
  bit         vert [2][NP];
  logic [7:0] m_joy [2];
  logic [1:0] m_chg [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < SYNC; k++) pipe[i][k] = '0;
      stab[i] = '0; stabq[i] = '0; m_joy[i] = '0; m_chg[i] = '0;
      for (int b = 0; b < 8; b++) run[i][b] = 0;
      for (int p = 0; p < NP; p++) begin
        last_h[i][p] = 0; last_v[i][p] = 0; vert[i][p] = 0;
      end
    end
  endtask

  task automatic model_step(input logic [7:0] jin, input logic [1:0] md);
    logic [7:0] s, st, rise, nj;
    logic [1:0] hx, vx;
    logic [3:0] nib;
    bit r, l, dn, up;
    for (int i = 0; i < 2; i++) begin
      s    = pipe[i][SYNC-1];
      st   = (deb[i] == 0) ? s : stab[i];
      rise = st & ~stabq[i];
      nj   = '0;
      for (int p = 0; p < NP; p++) begin
        r = st[4*p]; l = st[4*p+1]; dn = st[4*p+2]; up = st[4*p+3];
        if (rise[4*p+1])      last_h[i][p] = 2;
        else if (rise[4*p])   last_h[i][p] = 1;
        if (rise[4*p+3])      last_v[i][p] = 2;
        else if (rise[4*p+2]) last_v[i][p] = 1;
        if (rise[4*p+3] || rise[4*p+2])    vert[i][p] = 1;
        else if (rise[4*p+1] || rise[4*p]) vert[i][p] = 0;
        if (l && r) hx = (last_h[i][p] == 2) ? 2'b10 : (last_h[i][p] == 1) ? 2'b01 : 2'b00;
        else        hx = {l, r};
        if (up && dn) vx = (last_v[i][p] == 2) ? 2'b10 : (last_v[i][p] == 1) ? 2'b01 : 2'b00;
        else          vx = {up, dn};
        if (md == 2'd2)                                 nib = {2'b00, hx};
        else if (md == 2'd1 && hx != 0 && vx != 0)      nib = vert[i][p] ? {vx, 2'b00} : {2'b00, hx};
        else                                            nib = {vx, hx};
        m_chg[i][p] = (nib != m_joy[i][4*p +: 4]);
        nj[4*p +: 4] = nib;
      end
      m_joy[i] = nj;
      stabq[i] = st;
      if (deb[i] > 0) begin
        for (int b = 0; b < 8; b++) begin
          if (s[b] == stab[i][b]) run[i][b] = 0;
          else begin
            run[i][b]++;
            if (run[i][b] == deb[i]) begin
              stab[i][b] = s[b];
              run[i][b]  = 0;
            end
          end
        end
      end
      for (int k = SYNC - 1; k > 0; k--) pipe[i][k] = pipe[i][k-1];
      pipe[i][0] = jin;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step(joy_in, mode);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) begin
      chk("d0_joy", joy0, m_joy[0]);
      chk("d0_chg", 8'(chg0), 8'(m_chg[0]));
      chk("d4_joy", joy4, m_joy[1]);
      chk("d4_chg", 8'(chg4), 8'(m_chg[1]));
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_joy0", joy0, 8'h00);
    chk("rst_async_joy4", joy4, 8'h00);
    chk("rst_async_chg0", 8'(chg0), 8'h00);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  int cnt1;

  initial begin
    rst_n  = 1'b0;
    joy_in = 8'h00;
    mode   = 2'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_joy0", joy0, 8'h00);
    chk("reset_chg0", 8'(chg0), 8'h00);
    chk("reset_joy4", joy4, 8'h00);
    chk("reset_chg4", 8'(chg4), 8'h00);
    #2 rst_n = 1'b1;
    ticks(2);

    // T1: 2-way, latency and last-pressed on the horizontal axis
    joy_in = 8'h01;
    ticks(2);
    chk("t1_before_lat", 8'(joy0[3:0]), 8'h00);
    tick();
    chk("t1_r", 8'(joy0[3:0]), 8'h01);
    chk("t1_chg", 8'(chg0), 8'h01);
    tick();
    chk("t1_chg_clear", 8'(chg0), 8'h00);
    joy_in = 8'h03; ticks(3);
    chk("t1_add_l", 8'(joy0[3:0]), 8'h02);
    joy_in = 8'h01; ticks(3);
    chk("t1_rel_l", 8'(joy0[3:0]), 8'h01);

    // T2: simultaneous presses
    mode = 2'd0; joy_in = 8'h00; ticks(4);
    joy_in = 8'h03; ticks(3);
    chk("t2_lr_sim", 8'(joy0[3:0]), 8'h02);
    joy_in = 8'h00; ticks(4);
    joy_in = 8'h0C; ticks(3);
    chk("t2_ud_sim", 8'(joy0[3:0]), 8'h08);

    // T3: 4-way restriction and live mode switch
    mode = 2'd1; joy_in = 8'h00; ticks(4);
    joy_in = 8'h01; ticks(3);
    chk("t3_r", 8'(joy0[3:0]), 8'h01);
    joy_in = 8'h09; ticks(3);
    chk("t3_add_u", 8'(joy0[3:0]), 8'h08);
    joy_in = 8'h01; ticks(3);
    chk("t3_rel_u", 8'(joy0[3:0]), 8'h01);
    joy_in = 8'h09; ticks(3);
    mode = 2'd0; tick();
    chk("t3_to_8way", 8'(joy0[3:0]), 8'h09);

    // T4: debounce rejects 3-cycle glitch, accepts hold at exact latency
    joy_in = 8'h00; ticks(10);
    joy_in = 8'h01; ticks(3);
    joy_in = 8'h00;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t4_glitch_joy", 8'(joy4[3:0]), 8'h00);
      chk("t4_glitch_chg", 8'(chg4), 8'h00);
    end
    joy_in = 8'h01; ticks(6);
    chk("t4_early", 8'(joy4[3:0]), 8'h00);
    tick();
    chk("t4_on_time", 8'(joy4[3:0]), 8'h01);
    chk("t4_chg", 8'(chg4), 8'h01);

    // T5: reset mid-hold, held bits re-rise together
    joy_in = 8'h00; ticks(10);
    joy_in = 8'h01; ticks(3);
    joy_in = 8'h03; ticks(3);
    chk("t5_pre", 8'(joy0[3:0]), 8'h02);
    do_reset();
    ticks(3);
    chk("t5_post", 8'(joy0[3:0]), 8'h02);

    // T6: players independent
    mode = 2'd1; joy_in = 8'h00; ticks(10);
    cnt1 = 0;
    joy_in = 8'h41;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        if (chg0[1]) cnt1++;
      end
      joy_in = (joy_in == 8'h41) ? 8'h42 : 8'h41;
    end
    chk("t6_p1_out", 8'(joy0[7:4]), 8'h04);
    chk("t6_p1_chg_cnt", 8'(cnt1), 8'h01);

    // Randomised traffic against the model
    for (int it = 0; it < 300; it++) begin
      joy_in = 8'($urandom);
      if ($urandom_range(0, 3) == 0) mode = 2'($urandom);
      ticks($urandom_range(1, 9));
      if ($urandom_range(0, 40) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
